sys_cntr_tx: RTL and testbench
==============================

Name: sys_cntr_tx

Overview:
- Transmit-side system controller. Collects register-file read results and ALU results, arbitrates between them, and serialises them as bytes into the UART transmitter through a valid/busy handshake.
- Sits between the reg_file/ALU outputs and the UART Tx parallel input. It is the counterpart of the receive-side command controller.
- Each source has a one-entry holding slot, so a result produced while the Tx is busy is not lost.

Parameters:
- width, 8, byte width of register data and UART frame payload.
- BUSY_TO, 15, cycles to wait for Tx_Busy to rise after a Tx_Valid pulse before re-issuing the same byte (range 2..255).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- RdData  in  width  register-file read data.
- RdData_Valid  in  1  one-cycle strobe; RdData is valid.
- ALU_OUT  in  2*width  ALU result.
- OUT_Valid  in  1  one-cycle strobe; ALU_OUT is valid.
- Tx_Busy  in  1  UART transmitter busy (high for the whole frame).
- Tx_P_Data  out  width  byte to transmit (registered).
- Tx_Valid  out  1  one-cycle transmit request (registered).
- Drop_Err  out  1  sticky flag: a result arrived while its slot was full.

Behaviour:
- Reset (async, Reset=0): Tx_P_Data=0, Tx_Valid=0, Drop_Err=0, both slots empty, state=IDLE, byte index=0, timeout counter=0, last_grant=ALU (so the first contested grant goes to RD).
- Slots:
  - rd_slot holds width bits; alu_slot holds 2*width bits. Each has a pending flag.
  - On a strobe, the data is captured at that edge if the slot is empty, or if the slot is released at that same edge (capture wins; pending stays 1).
  - Otherwise the data is discarded and Drop_Err is set to 1 at that edge. Drop_Err clears only on reset.
- Arbitration (IDLE only, evaluated when Tx_Busy=0):
  - One slot pending: grant it.
  - Both pending: round-robin, grant the source not granted last. Update last_grant.
  - Tx_Busy=1 in IDLE: no grant; stay in IDLE.
- FSM states: IDLE, SEND, WAIT_HI, WAIT_LO.
  - IDLE -> SEND on grant. At that edge, Tx_P_Data loads the byte: RD = rd_slot; ALU = alu_slot[width-1:0] first. Tx_Valid loads 1.
  - SEND: Tx_Valid=1 for exactly this one cycle. Next edge -> WAIT_HI, Tx_Valid<=0, counter<=0.
  - WAIT_HI:
    - Tx_Busy=1 -> WAIT_LO.
    - Otherwise counter++. When counter==BUSY_TO-1 -> SEND, re-issuing the same byte (Tx_Valid<=1).
  - WAIT_LO: Tx_Busy=1 holds the state. Tx_Busy=0:
    - ALU grant, byte index 0: byte index<=1, Tx_P_Data<=alu_slot[2*width-1:width], Tx_Valid<=1 -> SEND.
    - Otherwise: release the granted slot, byte index<=0 -> IDLE.
- Tx_P_Data holds its last value when Tx_Valid=0.
- Byte order for ALU results is LSB byte first, then MSB byte.
- Latency:
  - A strobe in cycle 0 with Tx idle and no other pending work gives Tx_Valid=1 in cycle 2.
  - Slot pending is visible in cycle 1; the grant edge ends cycle 1.
- Contention: the slot not being served stays pending. It is granted on the IDLE cycle after the current transfer completes.
- Strobe into the slot currently being transmitted: dropped with Drop_Err, except on the exact release edge.
- Reset asserted mid-transfer: immediate return to reset values. Partial ALU transfers are not resumed.

Decomposition:
- Shared package (sys_cntr_pkg):
  - FSM state encoding (2-bit: IDLE=00, SEND=01, WAIT_HI=11, WAIT_LO=10).
  - Grant encoding (GNT_RD=0, GNT_ALU=1).
- Sub-module sys_tx_slot:
  - Parameter W; inputs data/strobe/release; outputs q/pending/drop.
  - Instantiated twice: W=width and W=2*width. The top OR-accumulates the two drop outputs into Drop_Err.
- FSM, arbiter, timeout counter and output registers live in the top.

Test Plan:
- Single read: RdData=8'h5A with RdData_Valid in cycle 0, Tx_Busy model rises 2 cycles after Tx_Valid for 10 cycles -> exactly one Tx_Valid pulse in cycle 2, Tx_P_Data=8'h5A, then IDLE; Drop_Err=0.
- ALU result: ALU_OUT=16'hBEEF -> two pulses, first Tx_P_Data=8'hEF, second 8'hBE; the second pulse occurs only after Tx_Busy falls from the first frame.
- Contention: RdData=8'h11 and ALU_OUT=16'h2233 strobed in the same cycle -> byte sequence 11, 33, 22. Repeat from post-first state with 8'h44/16'h5566 strobed together -> 66, 55, 44 (round-robin).
- Overflow: two RdData strobes (8'h01, 8'h02) 3 cycles apart while Tx_Busy held high -> only 8'h01 transmitted; Drop_Err=1 and stays 1 until Reset.
- Timeout: Tx_Busy held 0 after the pulse with BUSY_TO=15 -> Tx_Valid re-pulses 16 cycles after the first with the same byte; it stops once Tx_Busy rises.
- Reset mid-ALU: assert Reset during WAIT_LO of byte 0 -> all outputs 0 asynchronously; no second byte after release; the next strobe is transmitted normally.

Source files
------------

// File: rtl/sys_cntr_pkg.sv
// rtl/sys_cntr_pkg.sv - shared state and grant encodings for the transmit controller
package sys_cntr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SEND    = 2'b01,
        ST_WAIT_HI = 2'b11,
        ST_WAIT_LO = 2'b10
    } state_e;

    typedef enum logic {
        GNT_RD  = 1'b0,
        GNT_ALU = 1'b1
    } gnt_e;

endpackage

// File: rtl/sys_tx_slot.sv
// rtl/sys_tx_slot.sv - one-entry holding slot with capture/release and drop detection
module sys_tx_slot #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] data_i,
    input  logic         strobe_i,
    input  logic         release_i,
    output logic [W-1:0] q_o,
    output logic         pending_o,
    output logic         drop_o
);

    logic [W-1:0] q_q;
    logic         pend_q;
    logic         capture;

    // A strobe lands when the slot is empty or being freed on this very edge.
    always_comb begin
        capture = strobe_i && (!pend_q || release_i);
        drop_o  = strobe_i && pend_q && !release_i;
    end

    // Slot contents and pending flag; capture wins over a same-edge release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q    <= '0;
            pend_q <= 1'b0;
        end else if (capture) begin
            q_q    <= data_i;
            pend_q <= 1'b1;
        end else if (release_i) begin
            pend_q <= 1'b0;
        end
    end

    assign q_o       = q_q;
    assign pending_o = pend_q;

endmodule

// File: rtl/sys_cntr_tx.sv
// rtl/sys_cntr_tx.sv - arbitrates reg-file and ALU results into UART Tx bytes
module sys_cntr_tx
    import sys_cntr_pkg::*;
#(
    parameter int width   = 8,
    parameter int BUSY_TO = 15
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [width-1:0]   RdData,
    input  logic               RdData_Valid,
    input  logic [2*width-1:0] ALU_OUT,
    input  logic               OUT_Valid,
    input  logic               Tx_Busy,
    output logic [width-1:0]   Tx_P_Data,
    output logic               Tx_Valid,
    output logic               Drop_Err
);

    localparam logic [7:0] CNT_LAST = 8'(BUSY_TO - 1);

    state_e             state_q, state_d;
    gnt_e               gnt_q, gnt_d;
    gnt_e               last_q, last_d;
    gnt_e               pick;
    logic               idx_q, idx_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [width-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               drop_q, drop_d;

    logic [width-1:0]   rd_q;
    logic [2*width-1:0] alu_q;
    logic               rd_pend, alu_pend;
    logic               rd_drop, alu_drop;
    logic               rd_rel, alu_rel;

    sys_tx_slot #(.W(width)) u_rd_slot (
        .clk_i     (CLK),
        .rst_ni    (Reset),
        .data_i    (RdData),
        .strobe_i  (RdData_Valid),
        .release_i (rd_rel),
        .q_o       (rd_q),
        .pending_o (rd_pend),
        .drop_o    (rd_drop)
    );

    sys_tx_slot #(.W(2*width)) u_alu_slot (
        .clk_i     (CLK),
        .rst_ni    (Reset),
        .data_i    (ALU_OUT),
        .strobe_i  (OUT_Valid),
        .release_i (alu_rel),
        .q_o       (alu_q),
        .pending_o (alu_pend),
        .drop_o    (alu_drop)
    );

    // Arbitration, handshake sequencing, busy timeout and slot release.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        drop_d  = drop_q | rd_drop | alu_drop;
        pick    = GNT_RD;
        rd_rel  = 1'b0;
        alu_rel = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!Tx_Busy && (rd_pend || alu_pend)) begin
                    if (rd_pend && alu_pend) begin
                        // Contested grant alternates; only contested grants move the pointer.
                        pick   = (last_q == GNT_ALU) ? GNT_RD : GNT_ALU;
                        last_d = pick;
                    end else begin
                        pick = rd_pend ? GNT_RD : GNT_ALU;
                    end
                    gnt_d   = pick;
                    data_d  = (pick == GNT_RD) ? rd_q : alu_q[width-1:0];
                    valid_d = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                valid_d = 1'b0;
                cnt_d   = '0;
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (Tx_Busy) begin
                    state_d = ST_WAIT_LO;
                end else if (cnt_q == CNT_LAST) begin
                    // Transmitter never acknowledged: re-issue the same byte.
                    valid_d = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WAIT_LO: begin
                if (!Tx_Busy) begin
                    if (gnt_q == GNT_ALU && !idx_q) begin
                        idx_d   = 1'b1;
                        data_d  = alu_q[2*width-1:width];
                        valid_d = 1'b1;
                        state_d = ST_SEND;
                    end else begin
                        rd_rel  = (gnt_q == GNT_RD);
                        alu_rel = (gnt_q == GNT_ALU);
                        idx_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= GNT_RD;
            last_q  <= GNT_ALU;
            idx_q   <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign Tx_P_Data = data_q;
    assign Tx_Valid  = valid_q;
    assign Drop_Err  = drop_q;

endmodule

// File: tb/tb_sys_cntr_tx.sv
// tb/tb_sys_cntr_tx.sv - self-checking bench for sys_cntr_tx
module tb_sys_cntr_tx;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic [7:0]  RdData = '0;
    logic        RdData_Valid = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        OUT_Valid = 1'b0;
    logic        Tx_Busy = 1'b0;
    logic [7:0]  Tx_P_Data;
    logic        Tx_Valid;
    logic        Drop_Err;

    sys_cntr_tx #(.width(8), .BUSY_TO(15)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .ALU_OUT      (ALU_OUT),
        .OUT_Valid    (OUT_Valid),
        .Tx_Busy      (Tx_Busy),
        .Tx_P_Data    (Tx_P_Data),
        .Tx_Valid     (Tx_Valid),
        .Drop_Err     (Drop_Err)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [7:0] got_b[$];
    int         got_c[$];
    int         falls[$];
    logic [7:0] exp_b[$];
    int busy_mode = 0;
    int skip = 0;
    int dly  = 0;
    int len  = 0;
    int m_last = 1;

    // UART model: records every request, raises busy 2 cycles later for 10 cycles.
    initial forever begin
        @(negedge CLK);
        if (Tx_Valid) begin
            got_b.push_back(Tx_P_Data);
            got_c.push_back(cyc);
        end
        if (busy_mode == 1) begin
            Tx_Busy = 1'b1; dly = 0; len = 0;
        end else if (Tx_Valid) begin
            if (skip > 0) skip--; else dly = 2;
        end else if (dly > 0) begin
            dly--;
            if (dly == 0) begin Tx_Busy = 1'b1; len = 10; end
        end else if (len > 0) begin
            len--;
            if (len == 0) begin Tx_Busy = 1'b0; falls.push_back(cyc); end
        end else begin
            Tx_Busy = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic strobe(input bit do_rd, input bit do_alu, input logic [7:0] rd,
                          input logic [15:0] alu, output int s);
        @(negedge CLK);
        RdData = rd; RdData_Valid = do_rd;
        ALU_OUT = alu; OUT_Valid = do_alu;
        s = cyc;
        @(negedge CLK);
        RdData_Valid = 1'b0; OUT_Valid = 1'b0;
    endtask

    task automatic clear_obs();
        got_b.delete(); got_c.delete(); falls.delete(); exp_b.delete();
    endtask

    task automatic push_rd(input logic [7:0] d);
        exp_b.push_back(d);
    endtask

    task automatic push_alu(input logic [15:0] d);
        exp_b.push_back(d[7:0]);
        exp_b.push_back(d[15:8]);
    endtask

    // Both sources pending at once: the one not granted last goes first.
    task automatic push_both(input logic [7:0] rd, input logic [15:0] alu);
        if (m_last == 1) begin push_rd(rd); push_alu(alu); m_last = 0; end
        else begin push_alu(alu); push_rd(rd); m_last = 1; end
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_count"}, got_b.size(), exp_b.size());
        for (int i = 0; i < exp_b.size(); i++)
            if (i < got_b.size()) check({tag, "_byte"}, got_b[i], exp_b[i]);
    endtask

    initial begin
        int s;
        int k;
        logic [7:0]  r8;
        logic [15:0] r16;

        // Reset state
        wait_cyc(2);
        check("rst_pdata", Tx_P_Data, 0);
        check("rst_valid", Tx_Valid, 0);
        check("rst_drop", Drop_Err, 0);
        Reset = 1'b1;
        wait_cyc(2);

        // Single read: pulse two cycles after the strobe
        clear_obs(); push_rd(8'h5A);
        strobe(1, 0, 8'h5A, 16'h0, s);
        wait_cyc(30);
        check_seq("single_rd");
        if (got_c.size() > 0) check("single_rd_lat", got_c[0], s + 2);
        check("single_rd_drop", Drop_Err, 0);

        // ALU result: LSB byte then MSB byte, second only after busy falls
        clear_obs(); push_alu(16'hBEEF);
        strobe(0, 1, 8'h0, 16'hBEEF, s);
        wait_cyc(45);
        check_seq("alu");
        if (got_c.size() > 1 && falls.size() > 0) check("alu_second_after_fall", got_c[1], falls[0] + 1);

        // Contention and round-robin from a fresh reset
        @(negedge CLK); Reset = 1'b0; m_last = 1;
        @(negedge CLK); Reset = 1'b1;
        clear_obs(); push_both(8'h11, 16'h2233);
        strobe(1, 1, 8'h11, 16'h2233, s);
        wait_cyc(60);
        check_seq("contend1");
        clear_obs(); push_both(8'h44, 16'h5566);
        strobe(1, 1, 8'h44, 16'h5566, s);
        wait_cyc(60);
        check_seq("contend2");
        r8 = 8'($urandom); r16 = 16'($urandom);
        clear_obs(); push_both(r8, r16);
        strobe(1, 1, r8, r16, s);
        wait_cyc(60);
        check_seq("contend3");

        // Randomized single transfers
        for (int i = 0; i < 4; i++) begin
            r8 = 8'($urandom); r16 = 16'($urandom);
            clear_obs();
            if ($urandom_range(0, 1) == 0) begin
                push_rd(r8); strobe(1, 0, r8, 16'h0, s);
            end else begin
                push_alu(r16); strobe(0, 1, 8'h0, r16, s);
            end
            wait_cyc(45);
            check_seq("rand_single");
        end

        // Overflow while the transmitter is busy
        clear_obs(); push_rd(8'h01);
        busy_mode = 1;
        wait_cyc(2);
        strobe(1, 0, 8'h01, 16'h0, s);
        wait_cyc(1);
        check("ovf_drop_before", Drop_Err, 0);
        strobe(1, 0, 8'h02, 16'h0, s);
        check("ovf_drop_set", Drop_Err, 1);
        wait_cyc(5);
        check("ovf_no_tx_while_busy", got_b.size(), 0);
        busy_mode = 0;
        wait_cyc(40);
        check_seq("ovf");
        check("ovf_drop_sticky", Drop_Err, 1);
        @(negedge CLK); Reset = 1'b0; m_last = 1;
        #1 check("ovf_drop_cleared", Drop_Err, 0);
        @(negedge CLK); Reset = 1'b1;

        // Busy timeout: first request ignored, re-issued 16 cycles later
        r8 = 8'($urandom_range(1, 255));
        clear_obs(); push_rd(r8); push_rd(r8);
        skip = 1;
        strobe(1, 0, r8, 16'h0, s);
        wait_cyc(60);
        check_seq("timeout");
        if (got_c.size() > 1) check("timeout_gap", got_c[1] - got_c[0], 16);

        // Reset during WAIT_LO of the first ALU byte
        r16 = {8'($urandom), 8'($urandom_range(1, 255))};
        clear_obs(); exp_b.push_back(r16[7:0]);
        strobe(0, 1, 8'h0, r16, s);
        k = 0;
        while (!Tx_Busy && k < 20) begin @(negedge CLK); k++; end
        check("midrst_busy_seen", Tx_Busy, 1);
        @(negedge CLK);
        #2 Reset = 1'b0;
        #1;
        check("midrst_pdata", Tx_P_Data, 0);
        check("midrst_valid", Tx_Valid, 0);
        check("midrst_drop", Drop_Err, 0);
        @(negedge CLK); Reset = 1'b1; m_last = 1;
        wait_cyc(40);
        check_seq("midrst_no_resume");
        r8 = 8'($urandom);
        clear_obs(); push_rd(r8);
        strobe(1, 0, r8, 16'h0, s);
        wait_cyc(30);
        check_seq("midrst_after");
        if (got_c.size() > 0) check("midrst_after_lat", got_c[0], s + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
